// File: rtl/unary_add_n.sv
// Multi-lane serial unary accumulator/emitter: sums asserted lanes into a
// CW-bit count, then plays the count back as a run of ones on dout.
module unary_add_n #(
   parameter int NCH = 2,
   parameter int CW  = 3,
   parameter int SAT = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           clr,
   input  logic           mode,
   input  logic [NCH-1:0] din,
   output logic           dout,
   output logic           carry,
   output logic           done,
   output logic           ovf,
   output logic [CW-1:0]  count
);

   localparam int PW = $clog2(NCH + 1);
   // One bit above the wider operand so count + pop never truncates.
   localparam int SW = ((CW > PW) ? CW : PW) + 1;
   localparam logic [SW-1:0] CAP = {{(SW-CW){1'b0}}, {CW{1'b1}}};

   logic [PW-1:0] pop;
   logic [SW-1:0] sum;
   logic          over;

   logic [CW-1:0] count_nxt;
   logic          dout_nxt;
   logic          carry_nxt;
   logic          done_nxt;
   logic          ovf_nxt;

   always_comb begin
      pop = '0;
      for (int i = 0; i < NCH; i++) begin
         pop = pop + PW'(din[i]);
      end
   end

   assign sum  = {{(SW-CW){1'b0}}, count} + {{(SW-PW){1'b0}}, pop};
   assign over = (sum > CAP);

   always_comb begin
      count_nxt = count;
      ovf_nxt   = ovf;
      dout_nxt  = 1'b0;
      carry_nxt = 1'b0;
      done_nxt  = 1'b0;
      if (clr) begin
         count_nxt = '0;
         ovf_nxt   = 1'b0;
      end else if (en) begin
         if (!mode) begin
            if (over) begin
               carry_nxt = 1'b1;
               ovf_nxt   = 1'b1;
               // Wrap keeps the low bits; several wraps in one update still
               // report a single carry, ovf marks the value as unreliable.
               count_nxt = (SAT != 0) ? CAP[CW-1:0] : sum[CW-1:0];
            end else begin
               count_nxt = sum[CW-1:0];
            end
         end else if (count != '0) begin
            dout_nxt  = 1'b1;
            done_nxt  = (count == {{(CW-1){1'b0}}, 1'b1});
            count_nxt = count - {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         dout  <= 1'b0;
         carry <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         dout  <= dout_nxt;
         carry <= carry_nxt;
         done  <= done_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule

// File: doc/unary_add_n.md
# unary_add_n

Parametrised serial unary accumulator and emitter. During accumulate mode it sums the number of asserted bits on NCH unary input lanes each enabled cycle into a CW-bit count. During emit mode it plays the count back as a run of consecutive ones on a serial output. It is the multi-lane, width-configurable successor of the two-lane 3-bit unary adder, and adds:

- a single-cycle carry that is aligned to the overflowing update,
- a selectable wrap or saturate policy,
- a sticky overflow flag,
- synchronous clear,
- an end-of-emission pulse.

## Interface
Parameters:
- NCH, default 2: number of unary input lanes (≥1).
- CW, default 3: count register width (≥2); capacity is 2^CW − 1.
- SAT, default 0: overflow policy. 0 means wrap modulo 2^CW; 1 means clamp to 2^CW − 1.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  cycle enable; no state change when low, except clr.
- clr  input  1  synchronous clear; has priority over en and mode.
- mode  input  1  0 = accumulate, 1 = emit.
- din  input  NCH  unary lane bits; each 1 contributes +1.
- dout  output  1  serial unary output, registered.
- carry  output  1  one-cycle overflow pulse, registered.
- done  output  1  one-cycle end-of-emission pulse, registered.
- ovf  output  1  sticky overflow flag.
- count  output  CW  current accumulated value.

## Operation
- Reset (rst_n low, asynchronous): count, dout, carry, done and ovf all go to 0 immediately.
- Priority at each rising edge: clr, then en, then mode.
- clr=1 (regardless of en): count←0, ovf←0, dout←0, carry←0, done←0.
- en=0 and clr=0:
  - count and ovf hold.
  - dout, carry and done go to 0; they are pulse-type outputs and never stretch while disabled.
- Accumulate (en=1, mode=0):
  - pop = popcount(din), width ⌈log2(NCH+1)⌉.
  - sum = count + pop, computed at CW+1 bits plus enough headroom that it cannot truncate.
  - If sum ≤ 2^CW − 1: count←sum, carry←0.
  - If sum ≥ 2^CW: carry←1 and ovf←1.
    - SAT=0: count←sum mod 2^CW. Only one carry is reported per update, even if NCH ≥ 2^CW permits multiple wraps; ovf marks that the result is unreliable.
    - SAT=1: count←2^CW − 1.
  - dout←0 and done←0 throughout accumulate.
- Emit (en=1, mode=1):
  - din is ignored and carry←0.
  - If count ≠ 0: dout←1 and count←count − 1. done←1 only when count was 1, i.e. on the last one emitted.
  - If count = 0: dout←0, done←0. Emit on an empty count is legal and idle.
- Mode changes:
  - Mode may change on any cycle.
  - Switching emit→accumulate mid-run keeps the residual count; later additions add to it.
  - Switching accumulate→emit emits whatever count holds.
- ovf clears only on clr or reset; emitting does not clear it.

## Timing
- All outputs are registered and update on the edge that samples the inputs; there are no combinational input-to-output paths.
- Accumulate latency: count reflects din one cycle after the sampling edge. carry is high in the same cycle the wrapped or clamped count appears, with no extra flag stage.
- Emit: a count of K yields exactly K consecutive dout=1 cycles when en stays high. done coincides with the K-th one, and dout=0 on the following cycle.
- An en=0 gap during emit inserts dout=0 cycles without losing units; total ones emitted always equals the count at the start of emit.
- Back-to-back accumulate cycles at full rate: up to NCH units per cycle.

## Test plan
All scenarios use NCH=4, CW=4 unless noted.
- Basic add and emit:
  - Stimulus: din=4'b1011 for 2 accumulate cycles.
  - Response: count=6, carry=0. Then mode=1 → dout=1 for 6 cycles, done=1 on the 6th, count=0, dout=0 afterwards.
- Wrap (SAT=0):
  - Stimulus: count=14, din=4'b1111.
  - Response: count=2, carry=1 for exactly one cycle, ovf=1 and stays 1 through a later emit of 2 ones.
- Exact boundary:
  - Stimulus: count=11 + 4, then (after clr) count=12 + 4.
  - Response: first case count=15 with carry=0. Second case count=0, carry=1, ovf=1.
- Saturate (SAT=1):
  - Stimulus: count=14, din=4'b1111.
  - Response: count=15, carry=1, ovf=1; a further 4'b0001 keeps count=15 and pulses carry again.
- Enable gap and mode switch mid-emit:
  - Stimulus: count=5, emit 2 cycles, en=0 for 3 cycles, then mode=0 with din=4'b0011, then emit.
  - Response: dout=0 and count=3 held during the gap. count=5 after the add. Then 5 ones with done on the last.
- Clear and reset priority:
  - Stimulus A: clr=1 with en=1, mode=0, din=4'b1111.
  - Response A: count=0, ovf=0, carry=0.
  - Stimulus B: rst_n low mid-emit (between clock edges).
  - Response B: dout, done and count drop to 0 before the next edge.
